// File: rtl/zreg_readout.sv
// Z register readout: captures an ALU result and drains it onto the bus as one or two beats.
// Optional macro ZREG_FLAGS_EN enables capture-time zero/negative flags; otherwise they are tied to 0.
module zreg_readout #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic              alu_wide,
  input  logic [DATA_W-1:0] alu_rz_lo,
  input  logic [DATA_W-1:0] alu_rz_hi,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_hi,
  output logic              bus_last,
  output logic              busy,
  output logic              z_flag,
  output logic              n_flag
);

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] zlo_q, zlo_d;
  logic [DATA_W-1:0] zhi_q, zhi_d;
  logic              wide_q, wide_d;
  logic              cap;

  assign cap = (state_q == IDLE) && alu_valid;

  always_comb begin
    state_d = state_q;
    zlo_d   = zlo_q;
    zhi_d   = zhi_q;
    wide_d  = wide_q;
    case (state_q)
      IDLE: begin
        if (alu_valid) begin
          zlo_d   = alu_rz_lo;
          zhi_d   = alu_wide ? alu_rz_hi : '0;
          wide_d  = alu_wide;
          state_d = LO;
        end
      end
      LO: if (bus_ready) state_d = wide_q ? HI : IDLE;
      HI: if (bus_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      zlo_q   <= '0;
      zhi_q   <= '0;
      wide_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      zlo_q   <= zlo_d;
      zhi_q   <= zhi_d;
      wide_q  <= wide_d;
    end
  end

  // Outputs decode from held state only, so bus_ready never reaches bus_valid combinationally.
  assign alu_ready = (state_q == IDLE) && !clr;
  assign busy      = (state_q != IDLE);
  assign bus_valid = busy;
  assign bus_hi    = (state_q == HI);
  assign bus_last  = (state_q == HI) || ((state_q == LO) && !wide_q);
  assign bus_data  = (state_q == LO) ? zlo_q :
                     (state_q == HI) ? zhi_q : '0;

`ifdef ZREG_FLAGS_EN
  logic z_q, z_d, n_q, n_d;

  always_comb begin
    z_d = z_q;
    n_d = n_q;
    if (cap) begin
      if (alu_wide) begin
        z_d = ({alu_rz_hi, alu_rz_lo} == '0);
        n_d = alu_rz_hi[DATA_W-1];
      end else begin
        z_d = (alu_rz_lo == '0);
        n_d = alu_rz_lo[DATA_W-1];
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else begin
      z_q <= z_d;
      n_q <= n_d;
    end
  end

  assign z_flag = z_q;
  assign n_flag = n_q;
`else
  logic unused_cap;
  assign unused_cap = cap;
  assign z_flag     = 1'b0;
  assign n_flag     = 1'b0;
`endif

endmodule

// File: tb/tb_zreg_readout.sv
// Bench for zreg_readout: directed results, scoreboard of expected bus beats checked by a monitor.
module tb_zreg_readout;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              clr;
  logic              alu_valid;
  logic              alu_ready;
  logic              alu_wide;
  logic [DATA_W-1:0] alu_rz_lo;
  logic [DATA_W-1:0] alu_rz_hi;
  logic [DATA_W-1:0] bus_data;
  logic              bus_valid;
  logic              bus_ready;
  logic              bus_hi;
  logic              bus_last;
  logic              busy;
  logic              z_flag;
  logic              n_flag;

  int checks   = 0;
  int failures = 0;

  // Expected beat: {bus_hi, bus_last, bus_data}
  logic [DATA_W+1:0] exp_q[$];

  zreg_readout #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .clr       (clr),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_wide  (alu_wide),
    .alu_rz_lo (alu_rz_lo),
    .alu_rz_hi (alu_rz_hi),
    .bus_data  (bus_data),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_hi    (bus_hi),
    .bus_last  (bus_last),
    .busy      (busy),
    .z_flag    (z_flag),
    .n_flag    (n_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a result for one accepting edge and records the beats it must produce.
  task automatic issue(input logic [DATA_W-1:0] lo, input logic [DATA_W-1:0] hi, input logic wide);
    alu_valid = 1'b1;
    alu_rz_lo = lo;
    alu_rz_hi = hi;
    alu_wide  = wide;
    exp_q.push_back({1'b0, !wide, lo});
    if (wide) exp_q.push_back({1'b1, 1'b1, hi});
    tick();
    alu_valid = 1'b0;
    alu_wide  = 1'b0;
    alu_rz_lo = 32'h5A5A_5A5A;
    alu_rz_hi = 32'hA5A5_A5A5;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check(name, {63'd0, busy}, 64'd0);
  endtask

  always @(negedge clk) begin
    if (bus_valid && bus_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got data=%h hi=%b last=%b expected no beat", bus_data, bus_hi, bus_last);
      end else begin
        check("bus_beat", {30'd0, bus_hi, bus_last, bus_data}, {30'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    logic exp_z, exp_n;
    clr       = 1'b1;
    alu_valid = 1'b0;
    alu_wide  = 1'b0;
    alu_rz_lo = '0;
    alu_rz_hi = '0;
    bus_ready = 1'b1;
    #1;
    check("rst_bus_valid", {63'd0, bus_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_bus_data", {32'd0, bus_data}, 64'd0);
    check("rst_flags", {62'd0, z_flag, n_flag}, 64'd0);
    tick();
    tick();
    clr = 1'b0;
    tick();
    check("rst_alu_ready", {63'd0, alu_ready}, 64'd1);

    // Narrow result
    issue(32'hABCD_1234, 32'h1111_1111, 1'b0);
    check("narrow_valid", {63'd0, bus_valid}, 64'd1);
    check("narrow_ready_low", {63'd0, alu_ready}, 64'd0);
    check("narrow_last", {62'd0, bus_hi, bus_last}, 64'd1);
    tick();
    check("narrow_done_valid", {63'd0, bus_valid}, 64'd0);
    check("narrow_ready_back", {63'd0, alu_ready}, 64'd1);
    check("idle_bus_data", {32'd0, bus_data}, 64'd0);

    // Wide result, consecutive beats
    issue(32'h0000_0033, 32'hFFFF_FFFF, 1'b1);
    check("wide_lo_data", {32'd0, bus_data}, 64'h33);
    check("wide_lo_hi_last", {62'd0, bus_hi, bus_last}, 64'd0);
    tick();
    check("wide_hi_data", {32'd0, bus_data}, 64'hFFFF_FFFF);
    check("wide_hi_hi_last", {62'd0, bus_hi, bus_last}, 64'd3);
    tick();
    check("wide_done_ready", {63'd0, alu_ready}, 64'd1);

    // Back-pressure with an ignored offer while busy
    bus_ready = 1'b0;
    issue(32'h0000_0033, 32'hFFFF_FFFF, 1'b1);
    alu_valid = 1'b1;
    alu_wide  = 1'b0;
    alu_rz_lo = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_data", {32'd0, bus_data}, 64'h33);
      check("bp_ready_low", {63'd0, alu_ready}, 64'd0);
      tick();
    end
    alu_valid = 1'b0;
    bus_ready = 1'b1;
    check("bp_fourth_data", {32'd0, bus_data}, 64'h33);
    tick();
    check("bp_hi_data", {32'd0, bus_data}, 64'hFFFF_FFFF);
    check("bp_hi_flag", {63'd0, bus_hi}, 64'd1);
    tick();
    tick();
    check("bp_no_extra", {63'd0, bus_valid}, 64'd0);

    // Reset while in HI
    issue(32'h1234_5678, 32'h8765_4321, 1'b1);
    tick();
    check("mid_in_hi", {63'd0, bus_hi}, 64'd1);
    #1 clr = 1'b1;
    #1;
    check("clr_bus_valid", {63'd0, bus_valid}, 64'd0);
    check("clr_busy", {63'd0, busy}, 64'd0);
    tick();
    exp_q.delete();
    clr = 1'b0;
    #1;
    check("clr_release_ready", {63'd0, alu_ready}, 64'd1);
    issue(32'h0F0F_0F0F, 32'h0, 1'b0);
    check("post_clr_data", {32'd0, bus_data}, 64'h0F0F_0F0F);
    wait_idle("post_clr_idle");

    // Flags
`ifdef ZREG_FLAGS_EN
    exp_z = 1'b1; exp_n = 1'b0;
`else
    exp_z = 1'b0; exp_n = 1'b0;
`endif
    issue(32'h0, 32'hFFFF_FFFF, 1'b0);
    check("flags_narrow_zero", {62'd0, z_flag, n_flag}, {62'd0, exp_z, exp_n});
    wait_idle("flags_narrow_idle");
`ifdef ZREG_FLAGS_EN
    exp_z = 1'b0; exp_n = 1'b1;
`endif
    issue(32'h0, 32'h8000_0000, 1'b1);
    check("flags_wide_neg", {62'd0, z_flag, n_flag}, {62'd0, exp_z, exp_n});
    wait_idle("flags_wide_idle");
    tick();
    check("flags_hold", {62'd0, z_flag, n_flag}, {62'd0, exp_z, exp_n});

    check("scoreboard_empty", {32'd0, exp_q.size()}, 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
